// File: rtl/gps_wb_sweep_master.sv
// Wishbone master that sweeps per-channel registers on each epoch
// and also serves single host read/write commands.
module gps_wb_sweep_master #(
  parameter int NREG    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        epoch_i,
  input  logic [7:0]  ch_en_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [15:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  output logic        rd_valid_o,
  input  logic        rd_ready_i,
  output logic [31:0] rd_dat_o,
  output logic [16:0] rd_tag_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic        busy_o,
  output logic        overrun_o,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, BUS, WAIT_OUT} state_t;

  state_t      state, state_nxt;
  logic        pending, busy, overrun, err;
  logic [7:0]  mask;
  logic [2:0]  ch;
  logic [5:0]  rg;
  logic        stb, we, src;
  logic [15:0] adr;
  logic [31:0] dat;
  logic [7:0]  cnt;
  logic        rd_valid;
  logic [31:0] rd_dat;
  logic [16:0] rd_tag;

  logic        first_ok, next_ok;
  logic [2:0]  first_ch, next_ch;
  logic        accept_cmd, start_sweep;
  logic        hit, tmo, xfer, last_reg, more;

  assign cmd_ready_o = (state == IDLE) && !busy && !rd_valid;
  assign rd_valid_o  = rd_valid;
  assign rd_dat_o    = rd_dat;
  assign rd_tag_o    = rd_tag;
  assign wb_adr_o    = {16'h0000, adr};
  assign wb_dat_o    = dat;
  assign wb_we_o     = we;
  assign wb_stb_o    = stb;
  assign wb_cyc_o    = stb;
  assign busy_o      = busy;
  assign overrun_o   = overrun;
  assign err_o       = err;

  // Lowest enabled channel at start, and next enabled one after ch.
  always_comb begin
    first_ok = 1'b0;
    first_ch = 3'd0;
    next_ok  = 1'b0;
    next_ch  = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (ch_en_i[k]) begin
        first_ok = 1'b1;
        first_ch = 3'(k);
      end
      if (mask[k] && (3'(k) > ch)) begin
        next_ok = 1'b1;
        next_ch = 3'(k);
      end
    end
  end

  // Event strobes shared by the FSM and the datapath.
  always_comb begin
    accept_cmd  = cmd_valid_i && cmd_ready_o;
    start_sweep = (state == IDLE) && pending && !cmd_valid_i;
    hit         = (state == BUS) && stb && wb_ack_i;
    tmo         = (state == BUS) && stb && !wb_ack_i &&
                  (cnt == 8'(TIMEOUT));
    xfer        = (state == WAIT_OUT) && rd_valid && rd_ready_i;
    last_reg    = (rg == 6'(NREG - 1));
    more        = src && !(last_reg && !next_ok);
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept_cmd)
          state_nxt = BUS;
        else if (start_sweep && first_ok)
          state_nxt = BUS;
      end
      BUS: begin
        if (hit || tmo)
          state_nxt = we ? IDLE : WAIT_OUT;
      end
      WAIT_OUT: begin
        if (xfer)
          state_nxt = more ? BUS : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Bus, sweep position, result and status registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      pending  <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
      err      <= 1'b0;
      mask     <= '0;
      ch       <= '0;
      rg       <= '0;
      stb      <= 1'b0;
      we       <= 1'b0;
      src      <= 1'b0;
      adr      <= '0;
      dat      <= '0;
      cnt      <= '0;
      rd_valid <= 1'b0;
      rd_dat   <= '0;
      rd_tag   <= '0;
    end else begin
      if (epoch_i) begin
        if (busy || (start_sweep && first_ok))
          overrun <= 1'b1;
        else if (!start_sweep)
          pending <= 1'b1;
      end
      if (accept_cmd) begin
        adr <= cmd_adr_i;
        dat <= cmd_dat_i;
        we  <= cmd_we_i;
        src <= 1'b0;
      end else if (start_sweep) begin
        pending <= epoch_i && !first_ok;
        mask    <= ch_en_i;
        if (first_ok) begin
          busy <= 1'b1;
          ch   <= first_ch;
          rg   <= '0;
          adr  <= {8'h0A + {5'b0, first_ch}, 8'h00};
          dat  <= '0;
          we   <= 1'b0;
          src  <= 1'b1;
        end
      end
      if ((state == BUS) && !stb) begin
        stb <= 1'b1;
        cnt <= 8'd1;
      end else if (hit) begin
        stb <= 1'b0;
        if (!we) begin
          rd_valid <= 1'b1;
          rd_dat   <= wb_dat_i;
          rd_tag   <= {1'b0, src, adr};
        end
      end else if (tmo) begin
        stb <= 1'b0;
        err <= 1'b1;
        if (!we) begin
          rd_valid <= 1'b1;
          rd_dat   <= 32'hFFFF_FFFF;
          rd_tag   <= {1'b1, src, adr};
        end
      end else if (stb) begin
        cnt <= cnt + 8'd1;
      end
      if (xfer) begin
        rd_valid <= 1'b0;
        if (src) begin
          if (!last_reg) begin
            rg       <= rg + 6'd1;
            adr[7:0] <= {rg + 6'd1, 2'b00};
          end else if (next_ok) begin
            ch  <= next_ch;
            rg  <= '0;
            adr <= {8'h0A + {5'b0, next_ch}, 8'h00};
          end else begin
            busy <= 1'b0;
          end
        end
      end
    end
  end

endmodule
